// File: rtl/multi_alarm_reg.sv
// ---------------------------------------------------------------------------
// multi_alarm_reg
//   Bank of NUM_ALARMS alarm slots. Each slot holds a BCD time (HH:MM), an
//   enable bit, a ring flag and a one-cycle match history. A slot starts
//   ringing on the rising edge of "enabled and stored time == current time".
//   Ringing slots may be silenced (stop_al) or snoozed (advance the stored
//   time by SNOOZE_MIN minutes and clear the flag).
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   load_new_a, sel, new_alarm_*    load BCD time into slot sel (checked)
//   en_wr, en_val                   write enable bit of slot sel
//   cur_*                           current BCD clock time
//   snooze, stop_al                 snooze / silence all ringing slots
//   alarm_time_*, alarm_en_rd       registered readback of slot sel
//   ring_vec, ring                  per-slot ring flags and their OR
//   load_err                        one-cycle pulse after a rejected load
// ---------------------------------------------------------------------------
module multi_alarm_reg #(
  parameter int NUM_ALARMS = 4,
  parameter int ADDR_W     = 2,
  parameter int SNOOZE_MIN = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_new_a,
  input  logic [ADDR_W-1:0]     sel,
  input  logic [3:0]            new_alarm_ms_hr,
  input  logic [3:0]            new_alarm_ls_hr,
  input  logic [3:0]            new_alarm_ms_min,
  input  logic [3:0]            new_alarm_ls_min,
  input  logic                  en_wr,
  input  logic                  en_val,
  input  logic [3:0]            cur_ms_hr,
  input  logic [3:0]            cur_ls_hr,
  input  logic [3:0]            cur_ms_min,
  input  logic [3:0]            cur_ls_min,
  input  logic                  snooze,
  input  logic                  stop_al,
  output logic [3:0]            alarm_time_ms_hr,
  output logic [3:0]            alarm_time_ls_hr,
  output logic [3:0]            alarm_time_ms_min,
  output logic [3:0]            alarm_time_ls_min,
  output logic                  alarm_en_rd,
  output logic [NUM_ALARMS-1:0] ring_vec,
  output logic                  ring,
  output logic                  load_err
);

  // Times are kept as packed {ms_hr, ls_hr, ms_min, ls_min}.
  logic [15:0]           slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;
  logic [NUM_ALARMS-1:0] ring_q;
  logic [NUM_ALARMS-1:0] prev_eq;

  logic [15:0]           new_time;
  logic [15:0]           cur_time;
  logic                  sel_ok;
  logic                  load_ok;
  logic [NUM_ALARMS-1:0] sel_hit;
  logic [NUM_ALARMS-1:0] eq;
  logic [NUM_ALARMS-1:0] hit;
  logic [15:0]           rd_time;
  logic                  rd_en;

  // Valid 24-hour BCD time 00:00..23:59.
  function automatic logic time_ok(input logic [15:0] t);
    return (t[15:12] <= 4'd2) && (t[11:8] <= 4'd9) &&
           !((t[15:12] == 4'd2) && (t[11:8] > 4'd3)) &&
           (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  // Add SNOOZE_MIN minutes to a valid BCD time, carrying into the hour and
  // wrapping past midnight.
  function automatic logic [15:0] snooze_add(input logic [15:0] t);
    logic [4:0] hr;
    logic [6:0] mn;
    hr = 5'(t[15:12]) * 5'd10 + 5'(t[11:8]);
    mn = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
    if (mn >= 7'd60) begin
      mn = mn - 7'd60;
      hr = hr + 5'd1;
    end
    if (hr >= 5'd24) hr = hr - 5'd24;
    return {4'(hr / 5'd10), 4'(hr % 5'd10), 4'(mn / 7'd10), 4'(mn % 7'd10)};
  endfunction

  assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
  assign cur_time = {cur_ms_hr, cur_ls_hr, cur_ms_min, cur_ls_min};
  assign sel_ok   = (int'(sel) < NUM_ALARMS);
  assign load_ok  = load_new_a && sel_ok && time_ok(new_time);

  // Slot decode, match detection and readback mux. Out-of-range sel matches
  // no slot, so reads return zero and writes fall through harmlessly.
  always_comb begin
    sel_hit = '0;
    eq      = '0;
    hit     = '0;
    rd_time = '0;
    rd_en   = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      sel_hit[i] = (int'(sel) == i);
      eq[i]      = en_q[i] && (slot_time[i] == cur_time);
      hit[i]     = eq[i] && !prev_eq[i];
      if (sel_hit[i]) begin
        rd_time = slot_time[i];
        rd_en   = en_q[i];
      end
    end
  end

  // Slot state update. Priority per ring flag: load > enable clear >
  // stop_al > snooze > new hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot_time[i] <= '0;
      en_q    <= '0;
      ring_q  <= '0;
      prev_eq <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        prev_eq[i] <= eq[i];
        if (en_wr && sel_hit[i]) en_q[i] <= en_val;

        if (load_ok && sel_hit[i]) begin
          slot_time[i] <= new_time;
          prev_eq[i]   <= 1'b0;
        end else if (snooze && !stop_al && ring_q[i]) begin
          slot_time[i] <= snooze_add(slot_time[i]);
        end

        if (load_ok && sel_hit[i])                ring_q[i] <= 1'b0;
        else if (en_wr && sel_hit[i] && !en_val)  ring_q[i] <= 1'b0;
        else if (stop_al)                         ring_q[i] <= 1'b0;
        else if (snooze && ring_q[i])             ring_q[i] <= 1'b0;
        else if (hit[i])                          ring_q[i] <= 1'b1;
      end
    end
  end

  // Registered readback and load error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} <= '0;
      alarm_en_rd <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} <= rd_time;
      alarm_en_rd <= rd_en;
      load_err    <= load_new_a && !load_ok;
    end
  end

  assign ring_vec = ring_q;
  assign ring     = |ring_q;

endmodule

// File: doc/multi_alarm_reg.md
MULTI_ALARM_REG -- requirements
Module: multi_alarm_reg

Interface
REQ-001 Parameter NUM_ALARMS, default 4, number of alarm slots; legal range 1..16.
REQ-002 Parameter ADDR_W, default 2, slot-index width; SHALL satisfy 2**ADDR_W >= NUM_ALARMS.
REQ-003 Parameter SNOOZE_MIN, default 5, snooze increment in minutes; legal range 1..59.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 load_new_a  in  1  write new time into slot sel.
REQ-007 sel  in  ADDR_W  slot index for load, enable write and readback.
REQ-008 new_alarm_ms_hr / new_alarm_ls_hr / new_alarm_ms_min / new_alarm_ls_min  in  4 each  BCD time to load.
REQ-009 en_wr  in  1  write en_val into enable bit of slot sel.
REQ-010 en_val  in  1  enable value.
REQ-011 cur_ms_hr / cur_ls_hr / cur_ms_min / cur_ls_min  in  4 each  current BCD clock time.
REQ-012 snooze  in  1  snooze all ringing slots.
REQ-013 stop_al  in  1  silence all ringing slots.
REQ-014 alarm_time_ms_hr / alarm_time_ls_hr / alarm_time_ms_min / alarm_time_ls_min  out  4 each  registered readback of slot sel.
REQ-015 alarm_en_rd  out  1  registered readback of enable bit of slot sel.
REQ-016 ring_vec  out  NUM_ALARMS  per-slot ringing flags.
REQ-017 ring  out  1  OR of ring_vec.
REQ-018 load_err  out  1  one-cycle pulse on rejected load.

Function
REQ-019 Load SHALL be accepted only if time is valid BCD 00:00..23:59 (ms_hr<=2, ls_hr<=9, hour<=23, ms_min<=5, ls_min<=9) and sel<NUM_ALARMS; accepted value visible in slot on next edge.
REQ-020 Rejected load SHALL leave all slots unchanged and assert load_err for exactly the following cycle.
REQ-021 Accepted load SHALL clear ring flag and match history of that slot; enable bit unchanged.
REQ-022 en_wr with sel>=NUM_ALARMS SHALL be ignored without load_err.
REQ-023 Readback outputs SHALL reflect slot sel contents one cycle after sel/contents change (1-cycle latency); sel>=NUM_ALARMS reads zero.
REQ-024 Per slot, eq = enabled AND stored time == current time; prev_eq register SHALL hold last-cycle eq.
REQ-025 Hit SHALL occur when eq=1 and prev_eq=0; hit sets that slot's ring flag next edge; continuous equality SHALL NOT re-trigger.
REQ-026 Ring flag SHALL stay set until stop_al, snooze, accepted load to that slot, or clearing its enable bit.
REQ-027 stop_al SHALL clear all ring flags and suppress any hit in the same cycle.
REQ-028 snooze (without stop_al) SHALL, for each ringing slot, add SNOOZE_MIN minutes in BCD with carry min->hour and wrap 23:59->00:xx, clear its ring flag; non-ringing slots unaffected.
REQ-029 stop_al and snooze together: stop_al wins, times unchanged.
REQ-030 Simultaneous load and snooze on same ringing slot: load wins.
REQ-031 Multiple slots hitting same cycle SHALL all set their flags.
REQ-032 Clearing an enable bit SHALL clear that slot's ring flag same edge.

Reset
REQ-033 reset=1 at edge SHALL zero all slot times, enable bits, ring flags, prev_eq, readback outputs, ring and load_err; reset overrides all other inputs.
REQ-034 Reset mid-ring or mid-load SHALL leave no residual state; a slot at 00:00 SHALL NOT hit until enabled after reset.

Verification
REQ-035 Load slot 1 = 07:30, enable, drive cur 07:29 then 07:30 -> ring_vec=0010 one cycle after match, ring=1, holds while cur stays 07:30.
REQ-036 Load 24:00, then 12:60, then sel=5 with NUM_ALARMS=4 -> load_err pulses each, all slots unchanged on readback.
REQ-037 Slot 0 = 23:58 ringing, snooze with SNOOZE_MIN=5 -> slot 0 reads 00:03, ring_vec[0]=0, re-hits when cur=00:03.
REQ-038 Slots 0 and 2 both 06:00 enabled, match -> ring_vec=0101; stop_al+snooze same cycle -> ring_vec=0000, both still 06:00.
REQ-039 Slot ringing, assert reset for one cycle -> all outputs 0, readback 00:00, no ring though cur=00:00.
REQ-040 Slot 3 ringing, en_wr=1 en_val=0 sel=3 -> ring_vec[3]=0 next cycle, alarm_en_rd=0.
